// File: rtl/cond_unit_pkg.sv
// ---------------------------------------------------------------------------
// cond_unit_pkg
// Purpose : Shared constants for the condition/flag logic. The 4-bit
//           condition codes, NZCV bit positions inside the flag register and
//           the bit positions of the two FlagW write-enable halves. The
//           decoder and the ALU bench reuse the same constants.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package cond_unit_pkg;

  // Condition field encodings (instruction bits [31:28])
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // Bit positions of each flag inside the {N,Z,C,V} vector
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // Bit positions inside FlagW: upper bit writes N,Z; lower bit writes C,V
  localparam int unsigned FLAGW_NZ = 1;
  localparam int unsigned FLAGW_CV = 0;

endpackage

// File: rtl/cond_unit_if.sv
// ---------------------------------------------------------------------------
// cond_unit_if
// Purpose : Bundles the decoder/ALU-facing signals of the condition unit.
// Signals : en       - instruction valid / not stalled
//           Cond     - condition field [31:28]
//           ALUFlags - {N,Z,C,V} produced by the ALU this cycle
//           FlagW    - [1] write N,Z ; [0] write C,V
//           PCS/RegW/MemW - ungated write requests from the decoder
//           NoWrite  - compare-class op, suppresses the register write
//           PCSrc/RegWrite/MemWrite - gated write strobes
//           CarryIn  - stored C flag back to the ALU
//           CondEx   - condition passed
//           Flags    - stored {N,Z,C,V}
// Modports: master - decoder/datapath side (drives requests)
//           slave  - cond_unit side (drives gated strobes and flags)
// ---------------------------------------------------------------------------
interface cond_unit_if;

  logic       en;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic       NoWrite;
  logic       PCSrc;
  logic       RegWrite;
  logic       MemWrite;
  logic       CarryIn;
  logic       CondEx;
  logic [3:0] Flags;

  modport master (
    output en, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
    input  PCSrc, RegWrite, MemWrite, CarryIn, CondEx, Flags
  );

  modport slave (
    input  en, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
    output PCSrc, RegWrite, MemWrite, CarryIn, CondEx, Flags
  );

endinterface

// File: rtl/cond_unit_cond_check.sv
// ---------------------------------------------------------------------------
// cond_unit_cond_check
// Purpose : The cond_check block. Pure combinational evaluation of a 4-bit
//           condition code against an NZCV flag vector.
// Ports   : i_cond   in  4  condition field
//           i_flags  in  4  {N,Z,C,V}
//           o_condEx out 1  condition passed
// ---------------------------------------------------------------------------
module cond_unit_cond_check
  import cond_unit_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       o_condEx
);

  logic w_n;
  logic w_z;
  logic w_c;
  logic w_v;

  assign w_n = i_flags[FLAG_N];
  assign w_z = i_flags[FLAG_Z];
  assign w_c = i_flags[FLAG_C];
  assign w_v = i_flags[FLAG_V];

  // Condition table; the unused 1111 encoding behaves like AL
  always_comb begin
    o_condEx = 1'b1;
    case (i_cond)
      COND_EQ: o_condEx = w_z;
      COND_NE: o_condEx = ~w_z;
      COND_CS: o_condEx = w_c;
      COND_CC: o_condEx = ~w_c;
      COND_MI: o_condEx = w_n;
      COND_PL: o_condEx = ~w_n;
      COND_VS: o_condEx = w_v;
      COND_VC: o_condEx = ~w_v;
      COND_HI: o_condEx = w_c & ~w_z;
      COND_LS: o_condEx = ~w_c | w_z;
      COND_GE: o_condEx = (w_n == w_v);
      COND_LT: o_condEx = (w_n != w_v);
      COND_GT: o_condEx = ~w_z & (w_n == w_v);
      COND_LE: o_condEx = w_z | (w_n != w_v);
      COND_AL: o_condEx = 1'b1;
      default: o_condEx = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// ---------------------------------------------------------------------------
// cond_unit
// Purpose : Consumer end of the ALU flag interface. Holds the NZCV flag
//           register, evaluates the instruction condition against it,
//           returns the stored carry to the ALU and gates the decoder write
//           strobes so failed-condition instructions commit nothing.
// Params  : RESET_FLAGS - NZCV value loaded on reset
//           FLAG_BYPASS - 1: evaluate on ALUFlags after a flag-writing cycle
//                         (debug only); 0: always evaluate on stored flags
// Ports   : clk    in  1  system clock, rising edge
//           reset  in  1  synchronous, active-low reset
//           bus    cond_unit_if.slave - see cond_unit_if for signal list
// ---------------------------------------------------------------------------
module cond_unit
  import cond_unit_pkg::*;
#(
  parameter logic [3:0] RESET_FLAGS = 4'b0000,
  parameter bit         FLAG_BYPASS = 1'b0
)(
  input  logic        clk,
  input  logic        reset,
  cond_unit_if.slave  bus
);

  logic [3:0] r_flags;
  logic       r_flagsWritten;

  logic [3:0] w_evalFlags;
  logic       w_condPass;
  logic       w_flagWriteEn;

  // The bypass path only exists for debug builds; the normal build always
  // sees last cycle's committed flags, never the current ALU result.
  assign w_evalFlags = (FLAG_BYPASS && r_flagsWritten) ? bus.ALUFlags : r_flags;

  cond_unit_cond_check u_condCheck (
    .i_cond   (bus.Cond),
    .i_flags  (w_evalFlags),
    .o_condEx (w_condPass)
  );

  // Flags only change for a valid instruction whose condition passed
  assign w_flagWriteEn = reset & bus.en & w_condPass;

  // Flag register: reset wins over a same-edge write; the NZ and CV halves
  // are written independently so multiplies can leave C,V untouched.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_flags        <= RESET_FLAGS;
      r_flagsWritten <= 1'b0;
    end else begin
      if (w_flagWriteEn && bus.FlagW[FLAGW_NZ]) begin
        r_flags[FLAG_N] <= bus.ALUFlags[FLAG_N];
        r_flags[FLAG_Z] <= bus.ALUFlags[FLAG_Z];
      end
      if (w_flagWriteEn && bus.FlagW[FLAGW_CV]) begin
        r_flags[FLAG_C] <= bus.ALUFlags[FLAG_C];
        r_flags[FLAG_V] <= bus.ALUFlags[FLAG_V];
      end
      r_flagsWritten <= w_flagWriteEn & (|bus.FlagW);
    end
  end

  // Strobe gating: everything is forced low while reset is held; a stall
  // (en=0) blocks the strobes but CondEx still shows the evaluation.
  assign bus.CondEx   = reset & w_condPass;
  assign bus.PCSrc    = reset & bus.en & w_condPass & bus.PCS;
  assign bus.RegWrite = reset & bus.en & w_condPass & bus.RegW & ~bus.NoWrite;
  assign bus.MemWrite = reset & bus.en & w_condPass & bus.MemW;

  assign bus.CarryIn  = r_flags[FLAG_C];
  assign bus.Flags    = r_flags;

endmodule
